// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage core.
// Merges stall requests from IF, MEM and the ID load-use detector. Runs a
// small FSM that holds EX while a multi-cycle op (e.g. divide) executes.
// Drives the per-stage stall vector and the pipeline flush.
module pipe_ctrl #(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_stallreq_i,
  input  logic       mem_stallreq_i,
  input  logic       id_reg1_read_i,
  input  logic       id_reg2_read_i,
  input  logic [4:0] id_reg1_addr_i,
  input  logic [4:0] id_reg2_addr_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_wd_i,
  input  logic       ex_mc_start_i,
  input  logic       flush_i,
  output logic [5:0] stall_o,
  output logic       flush_o,
  output logic       mc_busy_o,
  output logic       mc_done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stall patterns: each freezes the named stage and everything upstream.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;

  // Counter preload: RUN lasts MC_CYCLES cycles, counting MC_CYCLES-1 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lu;
  logic             ex_stall;
  logic [5:0]       stall_vec;

  // A load in EX produces its data too late for forwarding into a reader in
  // ID. $0 is hardwired to zero, so a load targeting it is never a hazard.
  function automatic logic load_use(
    input logic       is_load,
    input logic [4:0] wd,
    input logic       rd1,
    input logic [4:0] addr1,
    input logic       rd2,
    input logic [4:0] addr2
  );
    logic hit1;
    logic hit2;
    hit1 = rd1 && (addr1 == wd);
    hit2 = rd2 && (addr2 == wd);
    return is_load && (wd != 5'd0) && (hit1 || hit2);
  endfunction

  // Highest-priority stall source wins; a flush discards everything anyway.
  function automatic logic [5:0] stall_select(
    input logic flush,
    input logic mem_req,
    input logic ex_req,
    input logic id_req,
    input logic if_req
  );
    logic [5:0] v;
    if (flush)        v = STALL_NONE;
    else if (mem_req) v = STALL_MEM;
    else if (ex_req)  v = STALL_EX;
    else if (id_req)  v = STALL_ID;
    else if (if_req)  v = STALL_IF;
    else              v = STALL_NONE;
    return v;
  endfunction

  assign lu = load_use(ex_is_load_i, ex_wd_i,
                       id_reg1_read_i, id_reg1_addr_i,
                       id_reg2_read_i, id_reg2_addr_i);

  // EX is held from the cycle the op is first seen until the counter expires.
  // In DONE the request level is still high but must not hold EX.
  assign ex_stall = ((state == IDLE) && ex_mc_start_i) || (state == RUN);

  // Combinational stall vector; reset forces all outputs low without a clock.
  always_comb begin
    stall_vec = stall_select(flush_i, mem_stallreq_i, ex_stall, lu, if_stallreq_i);
    stall_o   = rst ? STALL_NONE : stall_vec;
    flush_o   = flush_i && !rst;
    mc_busy_o = (state == RUN);
    mc_done_o = (state == DONE);
  end

  // State and counter register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: flush aborts from any state; DONE waits for EX to advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt   = CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mc_start_i) begin
            state_nxt = RUN;
            cnt_nxt   = CNT_LOAD;
          end
        end
        RUN: begin
          if (cnt == CNT_ZERO) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        DONE: begin
          if (!stall_vec[3]) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. Collects stall requests from IF, from ID (load-use hazards that the EX/MEM forwarding paths cannot resolve) and from MEM. Runs a small FSM that holds EX for multi-cycle operations such as divide. Produces the per-stage stall vector and the pipeline flush, and all pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb) obey these signals.

Parameters:
MC_CYCLES, 32, cycles EX stays occupied by a multi-cycle op after acceptance; legal range 1..63
CNT_W, 6, width of the multi-cycle down-counter; must satisfy 2^CNT_W > MC_CYCLES

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset; asynchronous, active-high
if_stallreq_i  in  1  instruction fetch not ready
mem_stallreq_i  in  1  data memory access not complete
id_reg1_read_i  in  1  ID reads rs (reg1_read from decode)
id_reg2_read_i  in  1  ID reads rt (reg2_read from decode)
id_reg1_addr_i  in  5  rs address in ID
id_reg2_addr_i  in  5  rt address in ID
ex_is_load_i  in  1  instruction in EX is a load
ex_wd_i  in  5  destination register of the instruction in EX
ex_mc_start_i  in  1  instruction in EX is multi-cycle; level, held while it sits in EX
flush_i  in  1  exception/redirect flush request
stall_o  out  6  stall vector: bit0 pc, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
flush_o  out  1  clear all pipeline registers
mc_busy_o  out  1  multi-cycle op in progress
mc_done_o  out  1  multi-cycle result valid in EX

Behaviour:
- Reset, asynchronous while rst=1: state=IDLE, cnt=0. Outputs forced as follows: stall_o=6'b000000, flush_o=0, mc_busy_o=0, mc_done_o=0.
- Load-use hazard (combinational): lu = ex_is_load_i and ex_wd_i!=0 and ((id_reg1_read_i and id_reg1_addr_i==ex_wd_i) or (id_reg2_read_i and id_reg2_addr_i==ex_wd_i)).
- Register $0 never causes a hazard.
- ex_stall (combinational) = (state==IDLE and ex_mc_start_i) or state==RUN.
- stall_o is combinational. Priority, highest first:
  - flush_i -> 000000
  - mem_stallreq_i -> 011111
  - ex_stall -> 001111
  - lu -> 000111
  - if_stallreq_i -> 000011
  - otherwise 000000
- flush_o = flush_i (combinational, same cycle).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ex_mc_start_i=1 and flush_i=0 -> RUN, cnt<=MC_CYCLES-1.
  - Otherwise stay in IDLE.
- RUN:
  - mc_busy_o=1.
  - cnt decrements every cycle, independent of mem_stallreq_i.
  - cnt==0 -> DONE.
  - Occupancy is exactly MC_CYCLES cycles in RUN.
- DONE:
  - mc_done_o=1 and the EX stall is released.
  - Go to IDLE on the first cycle with stall_o[3]==0, i.e. when EX advances.
  - Stay in DONE while MEM stalls, holding mc_done_o=1. ex_mc_start_i remains high in DONE and must not restart the op.
- Flush: in any state, flush_i=1 -> IDLE and cnt<=0 at the next edge. mc_done_o is not asserted for a flushed op.
- Latency: start seen in cycle t. EX is stalled in cycles t..t+MC_CYCLES. mc_done_o=1 from cycle t+MC_CYCLES+1, and EX advances at the end of that cycle when MEM is not stalled.
- Back-to-back multi-cycle ops: the second op starts from IDLE on the cycle after DONE exits.
- mc_busy_o = (state==RUN). mc_done_o = (state==DONE).
- No combinational path from any *_o output back to an input.

Test Plan:
1. Reset applied mid-RUN (MC_CYCLES=4, cnt=2) -> all outputs go to 0 immediately without waiting for clk. After release, state is IDLE and no mc_done_o pulse appears.
2. ex_is_load_i=1, ex_wd_i=5, id_reg2_read_i=1, id_reg2_addr_i=5 -> stall_o=000111. Then ex_wd_i=0 with id_reg2_addr_i=0 -> stall_o=000000.
3. MC_CYCLES=4, ex_mc_start_i held high from t0 -> stall_o=001111 for t0..t4, mc_busy_o=1 for t1..t4, mc_done_o=1 at t5 with stall_o=000000, IDLE at t6.
4. MC_CYCLES=4 with mem_stallreq_i=1 during t3..t6 -> stall_o=011111 for t3..t6. DONE is reached at t5 and held until t7, with mc_done_o=1 for t5..t7 and IDLE at t8.
5. flush_i=1 at t2 of a multi-cycle op -> flush_o=1 and stall_o=000000 at t2. State is IDLE at t3 and mc_done_o never asserts.
6. if_stallreq_i=1 together with lu=1 -> stall_o=000111. Adding mem_stallreq_i=1 -> stall_o=011111.
